// File: rtl/mem_copy_initiator.sv
// Block-copy master: moves num_words 64-bit words from src to dst.
// Each word is one read followed by one write on the req/gnt SRAM port.
module mem_copy_initiator #(
    parameter int unsigned AddrWidth  = 64,
    parameter int unsigned DataWidth  = 64,
    parameter int unsigned StrbWidth  = DataWidth / 8,
    parameter int unsigned CountWidth = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [AddrWidth-1:0]  src_addr_i,
    input  logic [AddrWidth-1:0]  dst_addr_i,
    input  logic [CountWidth-1:0] num_words_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    output logic [AddrWidth-1:0]  mem_addr_o,
    output logic [DataWidth-1:0]  mem_wdata_o,
    output logic [StrbWidth-1:0]  mem_strb_o,
    output logic                  mem_we_o,
    input  logic [DataWidth-1:0]  mem_rdata_i
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RWAIT,
        WR,
        DONE
    } state_e;

    localparam logic [AddrWidth-1:0] AlignMask = {{(AddrWidth-3){1'b1}}, 3'b000};

    state_e                state_q, state_d;
    logic [AddrWidth-1:0]  src_q, src_d;
    logic [AddrWidth-1:0]  dst_q, dst_d;
    logic [CountWidth-1:0] num_q, num_d;
    logic [CountWidth-1:0] idx_q, idx_d;
    logic [DataWidth-1:0]  data_q, data_d;
    logic [AddrWidth-1:0]  offset;

    // Byte offset of the current word; wraps modulo 2^AddrWidth with the add.
    assign offset = AddrWidth'(idx_q) << 3;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            num_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            num_q   <= num_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        num_d       = num_q;
        idx_d       = idx_q;
        data_d      = data_q;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_strb_o  = '0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    src_d   = src_addr_i & AlignMask;
                    dst_d   = dst_addr_i & AlignMask;
                    num_d   = num_words_i;
                    idx_d   = '0;
                    state_d = (num_words_i == '0) ? DONE : RD;
                end
            end
            RD: begin
                busy_o     = 1'b1;
                mem_req_o  = 1'b1;
                mem_addr_o = src_q + offset;
                if (mem_gnt_i) state_d = RWAIT;
            end
            RWAIT: begin
                // Read data is only registered here, so it never reaches an output combinationally.
                busy_o  = 1'b1;
                data_d  = mem_rdata_i;
                state_d = WR;
            end
            WR: begin
                busy_o      = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = dst_q + offset;
                mem_wdata_o = data_q;
                mem_strb_o  = '1;
                if (mem_gnt_i) begin
                    if (idx_q == num_q - CountWidth'(1)) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + CountWidth'(1);
                        state_d = RD;
                    end
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
